// File: rtl/ifu_pc_fetch.sv
// Instruction-fetch front end: PC register, next-PC select (redirect > stall > sequential) and imem port.
// Optional redirect-alignment checking is compiled in with `define IFU_MISALIGN_CHECK_EN.
module ifu_pc_fetch #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] dnpc,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  imem_ren,
    output logic [ADDR_WIDTH-1:0] imem_raddr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  misalign_err
);

    localparam int unsigned PC_STEP = 4;

    logic [ADDR_WIDTH-1:0] snpc;
    logic [ADDR_WIDTH-1:0] npc;
    logic                  dnpc_misaligned;

    assign snpc            = pc + ADDR_WIDTH'(PC_STEP);
    assign dnpc_misaligned = (dnpc[1:0] != 2'b00);

    // Next-PC select; a misaligned redirect holds the PC when checking is enabled
    always_comb begin
        npc = snpc;
        if (jump_en) begin
`ifdef IFU_MISALIGN_CHECK_EN
            npc = dnpc_misaligned ? pc : dnpc;
`else
            npc = dnpc;
`endif
        end else if (stall) begin
            npc = pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= npc;
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    // Sticky until the next aligned redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (jump_en) begin
            misalign_err <= dnpc_misaligned;
        end
    end
`else
    logic unused_misaligned;
    assign unused_misaligned = dnpc_misaligned;
    assign misalign_err      = 1'b0;
`endif

    // Memory reads are combinational; instruction is zeroed while in reset
    assign imem_ren   = ~rst;
    assign imem_raddr = pc;
    assign inst       = imem_ren ? imem_rdata : DATA_WIDTH'(0);

endmodule

// File: tb/tb_ifu_pc_fetch.sv
// Bench for ifu_pc_fetch: table of next-PC vectors through a scoreboard queue, plus reset sequences.
module tb_ifu_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic        jump_en;
        logic        stall;
        logic [31:0] dnpc;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] dnpc = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_ren;
    logic [31:0] imem_raddr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        misalign_err;

    int n_vec = 0;
    int n_bad = 0;

    vec_t vecs[$];
    exp_t sb[$];

    ifu_pc_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en      (jump_en),
        .dnpc         (dnpc),
        .stall        (stall),
        .imem_rdata   (imem_rdata),
        .imem_ren     (imem_ren),
        .imem_raddr   (imem_raddr),
        .pc           (pc),
        .inst         (inst),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    assign imem_rdata = mem_word(imem_raddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] exp_pc, input logic exp_err);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_raddr"}, imem_raddr, exp_pc);
        check({tag, "_ren"}, 32'(imem_ren), 32'd1);
        check({tag, "_inst"}, inst, mem_word(exp_pc));
        check({tag, "_err"}, 32'(misalign_err), 32'(exp_err));
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_pc"}, pc, RST_PC);
        check({tag, "_ren"}, 32'(imem_ren), 32'd0);
        check({tag, "_inst"}, inst, 32'd0);
        check({tag, "_err"}, 32'(misalign_err), 32'd0);
    endtask

    task automatic add(input logic j, input logic s, input logic [31:0] d,
                       input logic [31:0] epc, input logic eerr);
        vec_t v;
        v.jump_en = j; v.stall = s; v.dnpc = d; v.exp_pc = epc; v.exp_err = eerr;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge
    task automatic step(input string tag, input logic j, input logic s, input logic [31:0] d,
                        input logic [31:0] epc, input logic eerr);
        exp_t e;
        jump_en = j; stall = s; dnpc = d;
        e.pc = epc; e.err = eerr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL %s_sb: got empty scoreboard expected one entry", tag);
        end else begin
            e = sb.pop_front();
            check_fetch(tag, e.pc, e.err);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        add(0, 0, 32'h0, 32'h8000_0004, 0);
        add(0, 0, 32'h0, 32'h8000_0008, 0);
        add(0, 0, 32'h0, 32'h8000_000C, 0);
        add(0, 0, 32'h0, 32'h8000_0010, 0);
        add(0, 1, 32'h0, 32'h8000_0010, 0);
        add(0, 1, 32'h0, 32'h8000_0010, 0);
        add(0, 1, 32'h0, 32'h8000_0010, 0);
        add(1, 1, 32'h8000_0200, 32'h8000_0200, 0);
        add(1, 0, 32'h8000_0100, 32'h8000_0100, 0);
        add(0, 0, 32'h0, 32'h8000_0104, 0);
        add(1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
        add(0, 0, 32'h0, 32'h0000_0000, 0);
        add(0, 0, 32'h0, 32'h0000_0004, 0);
`ifdef IFU_MISALIGN_CHECK_EN
        add(1, 0, 32'h8000_0102, 32'h0000_0004, 1);
        add(0, 0, 32'h0, 32'h0000_0008, 1);
`else
        add(1, 0, 32'h8000_0102, 32'h8000_0102, 0);
        add(0, 0, 32'h0, 32'h8000_0106, 0);
`endif
        add(1, 0, 32'h8000_0104, 32'h8000_0104, 0);
        add(1, 0, 32'h8000_0040, 32'h8000_0040, 0);

        // Power-on reset: takes effect before any clock edge
        #1 rst = 1'b1;
        #2 check_in_reset("por");
        @(posedge clk); #1;
        check_in_reset("por_edge");
        rst = 1'b0;
        #1 check_fetch("first_fetch", RST_PC, 1'b0);

        foreach (vecs[i])
            step($sformatf("v%0d", i), vecs[i].jump_en, vecs[i].stall, vecs[i].dnpc,
                 vecs[i].exp_pc, vecs[i].exp_err);

        // Async reset mid-cycle with a redirect pending; the redirect must be dropped
        jump_en = 1'b1; stall = 1'b0; dnpc = 32'h1234_5670;
        #2 rst = 1'b1;
        #1 check_in_reset("mid_rst");
        @(posedge clk); #1;
        check_in_reset("mid_rst_edge");
        rst = 1'b0; jump_en = 1'b0;
        #1 check_fetch("mid_rst_rel", RST_PC, 1'b0);
        step("post_rst", 0, 0, 32'h0, 32'h8000_0004, 0);
        step("post_rst2", 0, 1, 32'h0, 32'h8000_0004, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
